// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry, defaults and slot record (SPRITE_FLIP_EN adds flip bit)
package sprite_pkg;

  localparam int GLYPH_DIM   = 16;
  localparam int GLYPH_SHIFT = 8;
  localparam int ROW_W       = 4;
  localparam int COL_W       = 4;
  localparam int COORD_W     = 10;

  localparam logic [23:0] DEF_TRANSPARENT = 24'h000000;
  localparam logic [23:0] DEF_BG_COLOR    = 24'h000000;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [7:0]         glyph;
    logic               visible;
`ifdef SPRITE_FLIP_EN
    logic               flip;
`endif
  } slot_t;

endpackage

// File: rtl/sprite_hit.sv
// rtl/sprite_hit.sv - one slot's coverage test and glyph row/col (SPRITE_FLIP_EN mirrors col)
module sprite_hit
  import sprite_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               visible,
`ifdef SPRITE_FLIP_EN
  input  logic               flip,
`endif
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic               hit,
  output logic [ROW_W-1:0]   row,
  output logic [COL_W-1:0]   col
);

  // One extra bit keeps x+16 from wrapping back to column 0 near the right edge.
  logic [COORD_W:0] px, py, sx, sy;
  logic [COL_W-1:0] dx;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};
  assign sx = {1'b0, x};
  assign sy = {1'b0, y};

  assign hit = visible
             && (px >= sx) && (px < sx + (COORD_W+1)'(GLYPH_DIM))
             && (py >= sy) && (py < sy + (COORD_W+1)'(GLYPH_DIM));

  assign row = pix_y[ROW_W-1:0] - y[ROW_W-1:0];
  assign dx  = pix_x[COL_W-1:0] - x[COL_W-1:0];

`ifdef SPRITE_FLIP_EN
  assign col = flip ? ~dx : dx;
`else
  assign col = dx;
`endif

endmodule

// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - sprite lookup to glyph ROM and RGB output, latency 3; optional SPRITE_FLIP_EN
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = 8,
  parameter logic [23:0] TRANSPARENT = DEF_TRANSPARENT,
  parameter logic [23:0] BG_COLOR    = DEF_BG_COLOR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_SPRITES)-1:0] wr_idx,
  input  logic [COORD_W-1:0]             wr_x,
  input  logic [COORD_W-1:0]             wr_y,
  input  logic [7:0]                     wr_glyph,
  input  logic                           wr_visible,
  input  logic                           wr_flip,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  input  logic                           video_on,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  output logic [GLYPH_SHIFT+7:0]         glyph_addr,
  input  logic [23:0]                    glyph_pixel,
  output logic [23:0]                    rgb_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           video_on_out
);

  slot_t shadow [NUM_SPRITES];
  slot_t active [NUM_SPRITES];
  slot_t wr_slot;

  assign wr_slot.x       = wr_x;
  assign wr_slot.y       = wr_y;
  assign wr_slot.glyph   = wr_glyph;
  assign wr_slot.visible = wr_visible;
`ifdef SPRITE_FLIP_EN
  assign wr_slot.flip    = wr_flip;
`else
  logic unused_flip;
  assign unused_flip = wr_flip;
`endif

  // Commit reads the shadow before this cycle's write lands, so a same-cycle write waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en)
        shadow[wr_idx] <= wr_slot;
      if (frame_start)
        active <= shadow;
    end
  end

  logic [NUM_SPRITES-1:0] hit_v;
  logic [ROW_W-1:0]       row_v [NUM_SPRITES];
  logic [COL_W-1:0]       col_v [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit u_hit (
      .x       (active[g].x),
      .y       (active[g].y),
      .visible (active[g].visible),
`ifdef SPRITE_FLIP_EN
      .flip    (active[g].flip),
`endif
      .pix_x   (pix_x),
      .pix_y   (pix_y),
      .hit     (hit_v[g]),
      .row     (row_v[g]),
      .col     (col_v[g])
    );
  end

  logic                   any_hit;
  logic [GLYPH_SHIFT+7:0] sel_addr;

  // Walk from lowest priority upward so slot 0 overrides everyone.
  always_comb begin
    any_hit  = 1'b0;
    sel_addr = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        any_hit  = 1'b1;
        sel_addr = {active[i].glyph, row_v[i], col_v[i]};
      end
    end
  end

  logic hit_d1, hit_d2;
  logic von_d1, von_d2;
  logic hs_d1, hs_d2;
  logic vs_d1, vs_d2;

  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_addr   <= '0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      von_d1       <= 1'b0;
      von_d2       <= 1'b0;
      hs_d1        <= 1'b0;
      hs_d2        <= 1'b0;
      vs_d1        <= 1'b0;
      vs_d2        <= 1'b0;
      rgb_out      <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
    end else begin
      if (any_hit)
        glyph_addr <= sel_addr;
      hit_d1       <= any_hit;
      von_d1       <= video_on;
      hs_d1        <= hsync_in;
      vs_d1        <= vsync_in;
      hit_d2       <= hit_d1;
      von_d2       <= von_d1;
      hs_d2        <= hs_d1;
      vs_d2        <= vs_d1;
      // A transparent winner shows background, never a lower-priority sprite.
      if (!von_d2 || !hit_d2 || glyph_pixel == TRANSPARENT)
        rgb_out <= BG_COLOR;
      else
        rgb_out <= glyph_pixel;
      hsync_out    <= hs_d2;
      vsync_out    <= vs_d2;
      video_on_out <= von_d2;
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// tb/tb_sprite_fetch.sv - directed bench for sprite_fetch with a registered glyph ROM model
module tb_sprite_fetch;

  localparam logic [23:0] BG = 24'h0000AA;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [9:0]  wr_x, wr_y;
  logic [7:0]  wr_glyph;
  logic        wr_visible, wr_flip;
  logic        frame_start;
  logic [9:0]  pix_x, pix_y;
  logic        video_on, hsync_in, vsync_in;
  logic [15:0] glyph_addr;
  logic [23:0] glyph_pixel;
  logic [23:0] rgb_out;
  logic        hsync_out, vsync_out, video_on_out;

  logic [23:0] rom [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  sprite_fetch #(.NUM_SPRITES(8), .TRANSPARENT(24'h000000), .BG_COLOR(BG)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_glyph     (wr_glyph),
    .wr_visible   (wr_visible),
    .wr_flip      (wr_flip),
    .frame_start  (frame_start),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .video_on     (video_on),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .glyph_addr   (glyph_addr),
    .glyph_pixel  (glyph_pixel),
    .rgb_out      (rgb_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .video_on_out (video_on_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) glyph_pixel <= rom[glyph_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, req);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_slot(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                            input logic [7:0] g, input logic vis, input logic flip);
    wr_idx = idx; wr_x = x; wr_y = y; wr_glyph = g; wr_visible = vis; wr_flip = flip;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                         input logic hs, input logic vs);
    pix_x = x; pix_y = y; video_on = von; hsync_in = hs; vsync_in = vs;
  endtask

  logic [2:0] pat [8];

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 24'h000000;
    rom[16'h0325] = 24'hFF0000;
    rom[16'h0513] = 24'h000000;
    rom[16'h0668] = 24'h00FF00;
    rom[16'h0611] = 24'h00FF00;
    rom[16'h0711] = 24'h0000FF;
    rom[16'h0811] = 24'h112233;
    rom[16'h0953] = 24'h445566;

    reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_glyph = '0;
    wr_visible = 1'b0; wr_flip = 1'b0; frame_start = 1'b0;
    set_pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step(2);
    check("reset_addr", 32'(glyph_addr), 32'h0);
    check("reset_rgb", 32'(rgb_out), 32'h0);
    check("reset_hs", 32'(hsync_out), 32'h0);
    check("reset_vs", 32'(vsync_out), 32'h0);
    check("reset_von", 32'(video_on_out), 32'h0);
    reset = 1'b0;
    set_pix(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    step(3);
    check("empty_rgb_bg", 32'(rgb_out), 32'(BG));

    // basic hit
    write_slot(3'd0, 10'd100, 10'd50, 8'd3, 1'b1, 1'b0);
    commit();
    set_pix(10'd105, 10'd52, 1'b1, 1'b0, 1'b0);
    step();
    check("t1_addr", 32'(glyph_addr), 32'h0325);
    step(2);
    check("t1_rgb", 32'(rgb_out), 32'hFF0000);

    // priority and transparency
    write_slot(3'd0, 10'd200, 10'd200, 8'd5, 1'b1, 1'b0);
    write_slot(3'd1, 10'd195, 10'd195, 8'd6, 1'b1, 1'b0);
    commit();
    set_pix(10'd203, 10'd201, 1'b1, 1'b0, 1'b0);
    step();
    check("t2_prio_addr", 32'(glyph_addr), 32'h0513);
    step(2);
    check("t2_transp_rgb", 32'(rgb_out), 32'(BG));
    set_pix(10'd196, 10'd196, 1'b1, 1'b0, 1'b0);
    step();
    check("t2_slot1_addr", 32'(glyph_addr), 32'h0611);
    step(2);
    check("t2_slot1_rgb", 32'(rgb_out), 32'h00FF00);

    // shadow/active double buffering
    write_slot(3'd2, 10'd300, 10'd100, 8'd7, 1'b1, 1'b0);
    set_pix(10'd301, 10'd101, 1'b1, 1'b0, 1'b0);
    step();
    check("t3_nocommit_hold", 32'(glyph_addr), 32'h0611);
    step(2);
    check("t3_nocommit_rgb", 32'(rgb_out), 32'(BG));
    commit();
    step();
    check("t3_commit_addr", 32'(glyph_addr), 32'h0711);
    step(2);
    check("t3_commit_rgb", 32'(rgb_out), 32'h0000FF);
    wr_idx = 3'd2; wr_x = 10'd300; wr_y = 10'd100; wr_glyph = 8'd8; wr_visible = 1'b1;
    wr_en = 1'b1; frame_start = 1'b1;
    step();
    wr_en = 1'b0; frame_start = 1'b0;
    step();
    check("t3_same_cycle_old", 32'(glyph_addr), 32'h0711);
    commit();
    step();
    check("t3_next_frame_new", 32'(glyph_addr), 32'h0811);
    step(2);
    check("t3_next_frame_rgb", 32'(rgb_out), 32'h112233);

    // right-edge no-wrap
    write_slot(3'd3, 10'd1020, 10'd400, 8'd9, 1'b1, 1'b0);
    commit();
    set_pix(10'd3, 10'd405, 1'b1, 1'b0, 1'b0);
    step();
    check("t4_nowrap_hold", 32'(glyph_addr), 32'h0811);
    step(2);
    check("t4_nowrap_rgb", 32'(rgb_out), 32'(BG));
    set_pix(10'd1023, 10'd405, 1'b1, 1'b0, 1'b0);
    step();
    check("t4_edge_addr", 32'(glyph_addr), 32'h0953);
    step(2);
    check("t4_edge_rgb", 32'(rgb_out), 32'h445566);

    // sync/video_on delay of exactly 3 cycles, {hs,vs,von}
    pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b011; pat[3] = 3'b001;
    pat[4] = 3'b101; pat[5] = 3'b010; pat[6] = 3'b111; pat[7] = 3'b000;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_pix(10'd0, 10'd0, pat[i][0], pat[i][2], pat[i][1]);
      else       set_pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      step();
      if (i >= 2)
        check($sformatf("t5_sync_%0d", i - 2), 32'({hsync_out, vsync_out, video_on_out}),
              32'(pat[i-2]));
    end
    set_pix(10'd196, 10'd196, 1'b0, 1'b0, 1'b0);
    step();
    check("t5_blank_addr", 32'(glyph_addr), 32'h0611);
    step(2);
    check("t5_blank_rgb", 32'(rgb_out), 32'(BG));

    // reset mid-line
    set_pix(10'd196, 10'd196, 1'b1, 1'b1, 1'b1);
    step(3);
    check("t6_pre_rgb", 32'(rgb_out), 32'h00FF00);
    reset = 1'b1;
    step();
    check("t6_rst_rgb", 32'(rgb_out), 32'h0);
    check("t6_rst_addr", 32'(glyph_addr), 32'h0);
    check("t6_rst_sync", 32'({hsync_out, vsync_out, video_on_out}), 32'h0);
    reset = 1'b0;
    commit();
    set_pix(10'd196, 10'd196, 1'b1, 1'b0, 1'b0);
    step();
    check("t6_cleared_addr", 32'(glyph_addr), 32'h0);
    step(2);
    check("t6_cleared_rgb", 32'(rgb_out), 32'(BG));

`ifdef SPRITE_FLIP_EN
    write_slot(3'd4, 10'd500, 10'd500, 8'h0A, 1'b1, 1'b1);
    commit();
    set_pix(10'd500, 10'd500, 1'b1, 1'b0, 1'b0);
    step();
    check("flip_col15", 32'(glyph_addr), 32'h0A0F);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
